// File: rtl/fifo_led_player.sv
// -----------------------------------------------------------------------------
// fifo_led_player
//
// Pops words from the read side of an upstream first-word-fall-through FIFO
// and shows each one on the LED outputs for DWELL_CYCLES enabled clock cycles.
// If the FIFO still holds data when a dwell ends, the next word is popped in
// that same cycle, so consecutive words are shown with no idle gap.
//
// Parameters
//   D_WIDTH       width of the FIFO word and of the LED output
//   DWELL_CYCLES  enabled cycles each word is displayed (1 .. 2^24-1)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   en          run enable; low freezes the dwell countdown and blocks pops
//   fifo_empty  FIFO read-side empty flag
//   fifo_data   FIFO head word, valid whenever fifo_empty is low
//   fifo_rd     one-cycle pop strobe (combinational)
//   led         registered pattern currently displayed
//   busy        registered, high while a word is being displayed
//   shown_cnt   registered count of popped words, wraps at 16 bits
//
// Build option
//   FIFO_LED_PLAYER_HOLD_LAST_EN  when defined, the last word stays on the LEDs
//                                 after the FIFO runs dry; otherwise the LEDs
//                                 are cleared when the player goes idle.
// -----------------------------------------------------------------------------
module fifo_led_player #(
  parameter int D_WIDTH      = 8,
  parameter int DWELL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_data,
  output logic               fifo_rd,
  output logic [D_WIDTH-1:0] led,
  output logic               busy,
  output logic [15:0]        shown_cnt
);

  localparam int            CW         = $clog2(DWELL_CYCLES + 1);
  // The cycle of the pop is the first display cycle, so the countdown
  // starts one below the dwell length.
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [D_WIDTH-1:0] led_q, led_d;
  logic [15:0]        shown_q, shown_d;
  logic               busy_q;
  logic               pop;
  logic [D_WIDTH-1:0] idle_led;

`ifdef FIFO_LED_PLAYER_HOLD_LAST_EN
  assign idle_led = led_q;
`else
  assign idle_led = '0;
`endif

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    shown_d = shown_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) pop = 1'b1;
      end
      SHOW: begin
        if (en) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            led_d   = idle_led;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop looks the same from either state: take the head word,
    // restart the dwell and count it.
    if (pop) begin
      state_d = SHOW;
      cnt_d   = DWELL_LOAD;
      led_d   = fifo_data;
      shown_d = shown_q + 16'd1;
    end

    // The strobe must stay low during reset because the registers ignore it.
    fifo_rd = pop && !rst;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      shown_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      shown_q <= shown_d;
      busy_q  <= (state_d == SHOW);
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign shown_cnt = shown_q;

endmodule

// File: tb/tb_fifo_led_player.sv
// -----------------------------------------------------------------------------
// tb_fifo_led_player
//
// Two instances: dut0 with DWELL_CYCLES=4 and dut1 with DWELL_CYCLES=1, each
// fed by a queue-based model of a first-word-fall-through FIFO. Every word
// pushed into a FIFO model is also pushed to that instance's scoreboard; when
// the instance pops, the LED value after the edge is compared with the
// scoreboard head. A vector table covers reset, single word, pause and
// enable-gated idle; hand-written sequences cover back-to-back words, reset
// mid-dwell, counter wrap and the one-cycle dwell.
// -----------------------------------------------------------------------------
module tb_fifo_led_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1;
  logic        empty0, empty1;
  logic [7:0]  data0, data1;
  logic        rd0, rd1;
  logic [7:0]  led0, led1;
  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;

  logic        rd_pre0, rd_pre1;
  logic [7:0]  fq0[$], fq1[$];
  logic [7:0]  sb0[$], sb1[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_led_player #(.D_WIDTH(8), .DWELL_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .fifo_empty(empty0), .fifo_data(data0),
    .fifo_rd(rd0), .led(led0), .busy(busy0), .shown_cnt(cnt0)
  );

  fifo_led_player #(.D_WIDTH(8), .DWELL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_rd(rd1), .led(led1), .busy(busy1), .shown_cnt(cnt1)
  );

  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic        rst;
    logic        en;
    logic        exp_rd;
    logic [7:0]  exp_led;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // LED value once the player has gone idle after showing 'last'.
  function automatic logic [7:0] idle_led(input logic [7:0] last);
`ifdef FIFO_LED_PLAYER_HOLD_LAST_EN
    return last;
`else
    return 8'h00 & last;
`endif
  endfunction

  function automatic vec_t mk(input logic push, input logic [7:0] data, input logic r,
                              input logic e, input logic erd, input logic [7:0] eled,
                              input logic ebusy, input logic [15:0] ecnt);
    vec_t v;
    v.push = push; v.data = data; v.rst = r; v.en = e;
    v.exp_rd = erd; v.exp_led = eled; v.exp_busy = ebusy; v.exp_cnt = ecnt;
    return v;
  endfunction

  task automatic refresh();
    empty0 = (fq0.size() == 0);
    data0  = empty0 ? 8'h00 : fq0[0];
    empty1 = (fq1.size() == 0);
    data1  = empty1 ? 8'h00 : fq1[0];
  endtask

  task automatic push0(input logic [7:0] w);
    fq0.push_back(w);
    sb0.push_back(w);
    refresh();
  endtask

  task automatic push1(input logic [7:0] w);
    fq1.push_back(w);
    sb1.push_back(w);
    refresh();
  endtask

  // One clock cycle: called and returning at posedge+1. The pop strobe is
  // sampled at the falling edge; registered outputs are checked after the edge.
  task automatic cycle();
    logic [7:0] exp;
    @(negedge clk);
    rd_pre0 = rd0;
    rd_pre1 = rd1;
    check("rd0_while_empty", {31'd0, rd_pre0 & empty0}, 32'd0);
    check("rd1_while_empty", {31'd0, rd_pre1 & empty1}, 32'd0);
    check("rd_during_reset", {31'd0, rst & (rd_pre0 | rd_pre1)}, 32'd0);
    @(posedge clk);
    #1;
    if (rd_pre0 && fq0.size() > 0) begin
      void'(fq0.pop_front());
      exp = sb0.pop_front();
      check("sb0_popped_word", {24'd0, led0}, {24'd0, exp});
    end
    if (rd_pre1 && fq1.size() > 0) begin
      void'(fq1.pop_front());
      exp = sb1.pop_front();
      check("sb1_popped_word", {24'd0, led1}, {24'd0, exp});
    end
    refresh();
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b0;
    en1 = 1'b0;
    rd_pre0 = 1'b0;
    rd_pre1 = 1'b0;
    refresh();

    // push, data, rst, en | rd before edge, led, busy, shown_cnt after edge
    vecs[0]  = mk(1, 8'hA5, 1, 1, 0, 8'h00, 0, 16'd0);
    vecs[1]  = mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 16'd0);
    vecs[2]  = mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 16'd0);
    vecs[3]  = mk(0, 8'h00, 0, 1, 1, 8'hA5, 1, 16'd1);
    vecs[4]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 16'd1);
    vecs[5]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 16'd1);
    vecs[6]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 16'd1);
    vecs[7]  = mk(0, 8'h00, 0, 1, 0, idle_led(8'hA5), 0, 16'd1);
    vecs[8]  = mk(0, 8'h00, 0, 1, 0, idle_led(8'hA5), 0, 16'd1);
    vecs[9]  = mk(1, 8'h3C, 0, 1, 1, 8'h3C, 1, 16'd2);
    vecs[10] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 1, 16'd2);
    for (int i = 11; i <= 15; i++) vecs[i] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 1, 16'd2);
    vecs[16] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 1, 16'd2);
    vecs[17] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 1, 16'd2);
    vecs[18] = mk(0, 8'h00, 0, 1, 0, idle_led(8'h3C), 0, 16'd2);
    vecs[19] = mk(1, 8'h5A, 0, 0, 0, idle_led(8'h3C), 0, 16'd2);
    vecs[20] = mk(0, 8'h00, 0, 0, 0, idle_led(8'h3C), 0, 16'd2);
    vecs[21] = mk(0, 8'h00, 0, 1, 1, 8'h5A, 1, 16'd3);
    vecs[22] = mk(0, 8'h00, 0, 1, 0, 8'h5A, 1, 16'd3);
    vecs[23] = mk(0, 8'h00, 0, 1, 0, 8'h5A, 1, 16'd3);
    vecs[24] = mk(0, 8'h00, 0, 1, 0, 8'h5A, 1, 16'd3);
    vecs[25] = mk(0, 8'h00, 0, 1, 0, idle_led(8'h5A), 0, 16'd3);

    @(posedge clk);
    #1;

    // Table: reset with data waiting, single word, pause, enable-gated idle.
    for (int i = 0; i < 26; i++) begin
      rst = vecs[i].rst;
      en0 = vecs[i].en;
      if (vecs[i].push) push0(vecs[i].data);
      cycle();
      check($sformatf("vec%0d_rd", i),   {31'd0, rd_pre0}, {31'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_led", i),  {24'd0, led0},    {24'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_busy", i), {31'd0, busy0},   {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_cnt", i),  {16'd0, cnt0},    {16'd0, vecs[i].exp_cnt});
    end

    // Back-to-back: three words, pops every 4 cycles, busy high 12 cycles.
    push0(8'h01);
    push0(8'h02);
    push0(8'h03);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check($sformatf("b2b%0d_rd", i), {31'd0, rd_pre0},
            {31'd0, (i < 12) && (i % 4 == 0)});
      check($sformatf("b2b%0d_led", i), {24'd0, led0},
            {24'd0, (i < 12) ? 8'(i / 4 + 1) : idle_led(8'h03)});
      check($sformatf("b2b%0d_busy", i), {31'd0, busy0}, {31'd0, i < 12});
    end
    check("b2b_shown_cnt", {16'd0, cnt0}, 32'd6);

    // Reset on the second display cycle of 0x77 with 0x88 queued.
    push0(8'h77);
    push0(8'h88);
    cycle();
    check("rstmid_rd_77", {31'd0, rd_pre0}, 32'd1);
    cycle();
    check("rstmid_led_77", {24'd0, led0}, 32'h77);
    rst = 1'b1;
    cycle();
    check("rstmid_rd_in_rst", {31'd0, rd_pre0}, 32'd0);
    check("rstmid_led_rst", {24'd0, led0}, 32'h00);
    check("rstmid_busy_rst", {31'd0, busy0}, 32'd0);
    check("rstmid_cnt_rst", {16'd0, cnt0}, 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cycle();
      check($sformatf("rstmid%0d_rd", j), {31'd0, rd_pre0}, {31'd0, j == 0});
      check($sformatf("rstmid%0d_led", j), {24'd0, led0}, 32'h88);
    end
    cycle();
    check("rstmid_led_idle", {24'd0, led0}, {24'd0, idle_led(8'h88)});
    check("rstmid_busy_idle", {31'd0, busy0}, 32'd0);
    check("rstmid_shown_cnt", {16'd0, cnt0}, 32'd1);

    // Counter wrap: preset the count to 0xFFFF, then pop one word.
    force dut0.shown_q = 16'hFFFF;
    #1;
    release dut0.shown_q;
    check("wrap_preset", {16'd0, cnt0}, 32'hFFFF);
    push0(8'h42);
    cycle();
    check("wrap_rd", {31'd0, rd_pre0}, 32'd1);
    check("wrap_cnt", {16'd0, cnt0}, 32'h0000);
    for (int j = 0; j < 4; j++) cycle();
    check("wrap_busy_idle", {31'd0, busy0}, 32'd0);

    // One-cycle dwell: eight words give eight consecutive pops.
    en1 = 1'b1;
    for (int i = 0; i < 8; i++) push1(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      cycle();
      check($sformatf("dw1_%0d_rd", i), {31'd0, rd_pre1}, {31'd0, i < 8});
      check($sformatf("dw1_%0d_led", i), {24'd0, led1},
            {24'd0, (i < 8) ? 8'(8'h10 + i) : idle_led(8'h17)});
      check($sformatf("dw1_%0d_busy", i), {31'd0, busy1}, {31'd0, i < 8});
    end
    check("dw1_shown_cnt", {16'd0, cnt1}, 32'd8);
    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_led_player.md
FIFO_LED_PLAYER -- requirements
Module: fifo_led_player

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: width of FIFO data word and LED output.
REQ-002 SHALL have parameter DWELL_CYCLES, default 4: clk cycles each word is displayed; legal range 1..2^24-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge; no other clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run enable; low freezes dwell countdown and suppresses pops.
REQ-006 SHALL have port fifo_empty  input  1  read-side empty flag of the upstream async FIFO.
REQ-007 SHALL have port fifo_data  input  D_WIDTH  FIFO head word, first-word-fall-through: valid whenever fifo_empty=0.
REQ-008 SHALL have port fifo_rd  output  1  single-cycle pop strobe to the FIFO's read-increment input.
REQ-009 SHALL have port led  output  D_WIDTH  registered pattern currently displayed.
REQ-010 SHALL have port busy  output  1  high while in SHOW state.
REQ-011 SHALL have port shown_cnt  output  16  registered count of words popped, wraps 0xFFFF->0x0000.

Function
REQ-012 SHALL implement FSM states IDLE and SHOW, plus a dwell down-counter of width $clog2(DWELL_CYCLES+1).
REQ-013 IDLE: when en=1 and fifo_empty=0, SHALL drive fifo_rd=1 combinationally that cycle; at the edge SHALL latch fifo_data into led, load counter with DWELL_CYCLES-1, increment shown_cnt, enter SHOW.
REQ-014 IDLE with fifo_empty=1 or en=0: fifo_rd SHALL stay 0, state and led unchanged.
REQ-015 SHOW with en=1 and counter>0: counter SHALL decrement by 1; fifo_rd=0.
REQ-016 SHOW with en=1, counter=0, fifo_empty=0: SHALL pop back-to-back exactly as REQ-013 and remain in SHOW (no idle gap between words).
REQ-017 SHOW with en=1, counter=0, fifo_empty=1: SHALL enter IDLE; led SHALL update per REQ-024/REQ-025.
REQ-018 SHOW with en=0: counter, led, state SHALL hold; fifo_rd=0; busy stays 1.
REQ-019 Each displayed word SHALL occupy led for exactly DWELL_CYCLES enabled cycles; DWELL_CYCLES=1 SHALL give one pop per cycle while FIFO non-empty.
REQ-020 fifo_rd SHALL never assert while fifo_empty=1 and never for more than one cycle per displayed word.
REQ-021 busy SHALL equal (state==SHOW), registered.

Reset
REQ-022 rst=1 at a clock edge SHALL force state=IDLE, counter=0, led=0, shown_cnt=0, busy=0; fifo_rd SHALL be 0 while rst=1.
REQ-023 Reset mid-SHOW SHALL abandon the current word (no further pop for it); first pop after release SHALL occur no earlier than the first edge with rst=0.

Configuration
REQ-024 Macro FIFO_LED_PLAYER_HOLD_LAST_EN defined: on SHOW->IDLE, led SHALL retain the last displayed word until the next pop or reset.
REQ-025 Macro FIFO_LED_PLAYER_HOLD_LAST_EN undefined: on SHOW->IDLE, led SHALL be cleared to 0 at the same edge.

Verification (D_WIDTH=8, DWELL_CYCLES=4)
REQ-026 Reset: hold rst=1 3 cycles with FIFO non-empty -> led=0x00, fifo_rd=0, busy=0, shown_cnt=0.
REQ-027 Single word: FIFO holds 0xA5, en=1 -> one fifo_rd pulse; led=0xA5 for exactly 4 cycles; then IDLE with led=0x00 (macro off) or 0xA5 (macro on); shown_cnt=1.
REQ-028 Back-to-back: FIFO holds 0x01,0x02,0x03 -> three fifo_rd pulses spaced exactly 4 cycles apart; led 0x01/0x02/0x03 each 4 cycles; busy continuously high 12 cycles; shown_cnt=3.
REQ-029 Pause: en dropped for 5 cycles during second cycle of 0x3C dwell -> led=0x3C for 4+5=9 cycles, no fifo_rd during pause.
REQ-030 Reset mid-dwell: rst pulsed on cycle 2 of 0x77 with 0x88 queued -> led=0x00 during reset; after release 0x88 popped and shown 4 cycles; shown_cnt=1.
REQ-031 Wrap: preload 65535 pops (or force) then one more -> shown_cnt=0x0000; DWELL_CYCLES=1 run of 8 words -> 8 consecutive fifo_rd cycles.
